conv_word_rx: RTL and testbench
===============================

# conv_word_rx

Host-link UART receiver for the convolution-result stream. Reassembles the byte pairs that the edge board transmits, high byte then low byte, into 16-bit convolution words. Also tracks the 16-word receptive-field frame. Sits on the loopback/bring-up FPGA, or on a second board, between the serial pin and the spike/neuron checking logic. Uses the same `baud_set` encoding as the board's transmitter.

## Interface
- `CLK_FREQ`, 50_000_000: system clock in Hz.
- `FRAME_WORDS`, 16: words per frame (receptive fields per image).
- `TIMEOUT_BITS`, 20: idle bit-times before a pending high byte is dropped (used only with the timeout feature).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial line, idle high, 8N1, LSB first, asynchronous to `clk`.
- `baud_set` in 3: 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200; values 5–7 are treated as 4.
- `rx_byte` out 8: last good byte.
- `byte_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `word` out 16: `{high, low}` of the last completed pair.
- `word_valid` out 1: one-cycle pulse when `word` updates.
- `word_idx` out 4: index (0..15) of the word carried by `word_valid`.
- `frame_done` out 1: one-cycle pulse with the last word of a frame.
- `framing_err` out 1: one-cycle pulse when the stop bit samples 0.
- `timeout` out 1: one-cycle pulse when a pending high byte is discarded.
- `rx_busy` out 1: high while a character is being received.

## Operation
- **Input synchronisation:** `rx` passes through a 2-flop synchroniser with reset value 1.
- **Oversampling:** 16x. The tick divider is `CLK_FREQ/(baud*16)`, rounded to nearest. `baud_set` is latched on the detected start edge; changes mid-character are ignored.
- **Bit sampling:** each bit is decided by a 2-of-3 majority of oversample ticks 7, 8 and 9.
- **State machine:**
  - IDLE → START on a synchronised falling edge of `rx`.
  - START: majority = 1 is a false start, return to IDLE with no pulse. Otherwise go to DATA.
  - DATA: 8 bits, LSB first, then STOP.
  - STOP: at the mid-bit decision, go to IDLE immediately. No wait for the end of the stop bit; a new start edge is accepted from then on.
- **Good stop (1):** `rx_byte` is updated and `byte_valid` pulses.
- **Bad stop (0):** `framing_err` pulses. The byte is discarded and the pending high byte is cleared, so the next byte is taken as a high byte. `word_idx` is unchanged.
- **Pairing:**
  - First good byte → stored as `hi`, pending flag set.
  - Second good byte → `word = {hi, byte}`, `word_valid` pulses, pending flag cleared.
  - `word_idx` is the index of the emitted word; the internal count then increments.
  - The word with index `FRAME_WORDS-1` also pulses `frame_done` in the same cycle, and the count wraps to 0.
- **Busy:** `rx_busy` is 1 in START, DATA and STOP.
- **Reset (any time, including mid-character):** all state returns to IDLE, the pending flag is cleared and the word count returns to 0. No pulse is emitted for the interrupted character.

## Timing
- Reset values:
  - `rx_byte`, `word`: 0.
  - `word_idx`: 0.
  - All pulse outputs: 0.
  - `rx_busy`: 0.
- Line edge to START entry: 3 clk (2 synchroniser + 1 edge register).
- `byte_valid` pulses 1 clk after the stop-bit majority decision.
- `word_valid` and `frame_done` pulse in the same cycle as `byte_valid` for a low byte; `word` and `word_idx` are stable from that cycle until the next `word_valid`.
- All pulses last exactly 1 clk.
- `framing_err` and `byte_valid` are mutually exclusive; `timeout` never coincides with `byte_valid`.

## Configuration
- Macro `CONV_WORD_RX_TIMEOUT_EN`.
- **Defined:** a bit-time counter runs while the pending flag is set and the state is IDLE. It is cleared on every start edge. When it reaches `TIMEOUT_BITS`:
  - the pending high byte is dropped and `word_idx` count resets to 0;
  - `timeout` pulses once.
- **Not defined:** `timeout` is tied to 0 and the counter is not built. Pairing resynchronises only on framing error or reset.

## Structure
- **Package `conv_link_pkg`** holds:
  - the baud enumeration matching `baud_set`;
  - the function computing the 16x divisor from `CLK_FREQ`;
  - the state enum (IDLE/START/DATA/STOP);
  - the constants `FRAME_WORDS_DEF = 16` and `OVS = 16`.
- **Sub-module `uart_rx_core`:** synchroniser, divider, state machine and majority sampler. Outputs are byte, `byte_valid`, `framing_err` and busy.
- The top level adds pairing, the word/frame counter and the optional timeout.

## Test plan
- **Single pair:** 115200 baud, `baud_set=4`, bytes 0x01, 0x23 → `word_valid` with `word=0x0123`, `word_idx=0`; `frame_done=0`.
- **Full frame:** 32 bytes forming words 0x0030..0x003F → 16 `word_valid` pulses with idx 0..15; `frame_done` with word 0x003F only; the next pair returns idx 0.
- **Framing error:** high byte 0xAA sent, then a byte with stop=0, then 0x12, 0x34 → `framing_err` pulse; next word = 0x1234 at unchanged idx.
- **False start:** 1-bit-time/4 low glitch on `rx` → no pulse; `rx_busy` falls within 1 bit time.
- **Timeout (macro on):** byte 0x55, then line idle for 21 bit times, then 0x66, 0x77 → `timeout` pulse; `word=0x6677`, idx 0.
- **Reset:** `rst` asserted during bit 4 of a low byte → all outputs 0; a following pair 0xBE, 0xEF gives `word=0xBEEF`, idx 0.

Source files
------------

// File: rtl/conv_link_pkg.sv
// Shared definitions for the convolution-result host link: baud encoding,
// 16x oversampling divisor table, receiver state encoding and frame constants.
package conv_link_pkg;

  localparam int          FRAME_WORDS_DEF = 16;
  localparam int unsigned OVS             = 16;
  localparam int          DIV_W           = 16;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Line rate in bit/s for a baud selector value.
  function automatic int unsigned baud_rate(baud_e sel);
    case (sel)
      BAUD_9600:   return 32'd9600;
      BAUD_19200:  return 32'd19200;
      BAUD_38400:  return 32'd38400;
      BAUD_57600:  return 32'd57600;
      BAUD_115200: return 32'd115200;
      default:     return 32'd115200;
    endcase
  endfunction

  // Selector values above the last defined rate behave as the fastest rate.
  function automatic logic [2:0] baud_clamp(logic [2:0] sel);
    return (sel > 3'd4) ? 3'd4 : sel;
  endfunction

  // Oversample divisors for all five rates, rounded to nearest, never zero.
  function automatic logic [4:0][DIV_W-1:0] div_table(int unsigned clk_freq);
    logic [4:0][DIV_W-1:0] tab;
    int unsigned           br;
    int unsigned           d;
    tab = '0;
    for (int i = 0; i < 5; i++) begin
      br = baud_rate(baud_e'(i[2:0]));
      d  = (clk_freq + (br * OVS) / 32'd2) / (br * OVS);
      if (d == 32'd0) begin
        d = 32'd1;
      end
      tab[i] = d[DIV_W-1:0];
    end
    return tab;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver core: 2-flop synchroniser, 16x tick divider, start/data/
// stop state machine with 2-of-3 majority sampling on ticks 7, 8 and 9.
// rx_data/rx_ok/rx_bad are decision-cycle strobes; the owner registers them.
module uart_rx_core
  import conv_link_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] baud_set,
  output logic [7:0] rx_data,
  output logic       rx_ok,
  output logic       rx_bad,
  output logic       busy
);

  localparam logic [4:0][DIV_W-1:0] DIV_TAB = div_table(CLK_FREQ);

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] tick_cnt_r;
  logic [3:0]       ovs_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [1:0]       samp_r;
  logic [7:0]       shift_r;
  logic             busy_r;

  logic fall_s;
  logic tick_s;
  logic decide_s;
  logic bit_end_s;
  logic maj_s;
  logic rx_ok_s;
  logic rx_bad_s;

  assign fall_s    = rx_prev_r & ~rx_sync_r;
  assign tick_s    = (tick_cnt_r == (div_r - 16'd1));
  assign decide_s  = tick_s & (ovs_cnt_r == 4'd9);
  assign bit_end_s = tick_s & (ovs_cnt_r == 4'd15);
  assign maj_s     = (samp_r[0] & samp_r[1]) | (samp_r[0] & rx_sync_r) |
                     (samp_r[1] & rx_sync_r);

  // Bring the asynchronous line into the clock domain and keep the previous
  // synchronised level for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state and decision strobes.
  always_comb begin
    state_nxt_s = state_r;
    rx_ok_s     = 1'b0;
    rx_bad_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s && maj_s) begin
          state_nxt_s = ST_IDLE;
        end else if (bit_end_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == 3'd7)) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          state_nxt_s = ST_IDLE;
          rx_ok_s     = maj_s;
          rx_bad_s    = ~maj_s;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and busy flag, which tracks the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Divider, oversample/bit counters, majority samples and data shifter.
  // The rate is captured on the start edge so baud_set may change freely
  // while a character is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r      <= DIV_TAB[4];
      tick_cnt_r <= '0;
      ovs_cnt_r  <= 4'd0;
      bit_cnt_r  <= 3'd0;
      samp_r     <= 2'b11;
      shift_r    <= 8'd0;
    end else if (state_r == ST_IDLE) begin
      if (fall_s) begin
        div_r      <= DIV_TAB[baud_clamp(baud_set)];
        tick_cnt_r <= '0;
        ovs_cnt_r  <= 4'd0;
        bit_cnt_r  <= 3'd0;
      end
    end else begin
      if (tick_s) begin
        tick_cnt_r <= '0;
        ovs_cnt_r  <= ovs_cnt_r + 4'd1;
        if (ovs_cnt_r == 4'd7) begin
          samp_r[0] <= rx_sync_r;
        end
        if (ovs_cnt_r == 4'd8) begin
          samp_r[1] <= rx_sync_r;
        end
      end else begin
        tick_cnt_r <= tick_cnt_r + 16'd1;
      end
      if ((state_r == ST_DATA) && decide_s) begin
        shift_r <= {maj_s, shift_r[7:1]};
      end
      if ((state_r == ST_DATA) && bit_end_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

  assign rx_data = shift_r;
  assign rx_ok   = rx_ok_s;
  assign rx_bad  = rx_bad_s;
  assign busy    = busy_r;

endmodule

// File: rtl/conv_word_rx.sv
// Convolution-word receiver: pairs received bytes (high then low) into
// 16-bit words and numbers them within a FRAME_WORDS-word frame.
// Optional feature macro CONV_WORD_RX_TIMEOUT_EN drops a stale high byte
// after TIMEOUT_BITS idle bit-times and restarts the frame count.
module conv_word_rx
  import conv_link_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int FRAME_WORDS  = FRAME_WORDS_DEF,
  parameter int TIMEOUT_BITS = 20
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [2:0]  baud_set,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic [15:0] word,
  output logic        word_valid,
  output logic [3:0]  word_idx,
  output logic        frame_done,
  output logic        framing_err,
  output logic        timeout,
  output logic        rx_busy
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_WORDS - 1);

  logic [7:0]  core_data_s;
  logic        core_ok_s;
  logic        core_bad_s;
  logic        core_busy_s;
  logic        to_fire_s;

  logic [7:0]  rx_byte_r;
  logic        byte_valid_r;
  logic [15:0] word_r;
  logic        word_valid_r;
  logic [3:0]  word_idx_r;
  logic        frame_done_r;
  logic        framing_err_r;
  logic        timeout_r;
  logic [7:0]  hi_r;
  logic        pend_r;
  logic [3:0]  cnt_r;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .baud_set (baud_set),
    .rx_data  (core_data_s),
    .rx_ok    (core_ok_s),
    .rx_bad   (core_bad_s),
    .busy     (core_busy_s)
  );

`ifdef CONV_WORD_RX_TIMEOUT_EN
  localparam logic [4:0][DIV_W-1:0] DIV_TAB = div_table(CLK_FREQ);
  localparam int TO_W = $clog2(TIMEOUT_BITS + 1);

  logic [DIV_W+3:0] to_clk_r;
  logic [TO_W-1:0]  to_bits_r;
  logic [DIV_W+3:0] bit_clks_s;

  assign bit_clks_s = {DIV_TAB[baud_clamp(baud_set)], 4'b0000};
  assign to_fire_s  = pend_r & ~core_busy_s & (to_bits_r == TO_W'(TIMEOUT_BITS));

  // Count idle bit-times while a high byte waits for its partner; any
  // reception activity or an empty pairing register restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_clk_r  <= '0;
      to_bits_r <= '0;
    end else if (!pend_r || core_busy_s) begin
      to_clk_r  <= '0;
      to_bits_r <= '0;
    end else if (to_clk_r == (bit_clks_s - 20'd1)) begin
      to_clk_r  <= '0;
      to_bits_r <= to_bits_r + 1'b1;
    end else begin
      to_clk_r  <= to_clk_r + 20'd1;
    end
  end
`else
  // TIMEOUT_BITS has no effect without the timeout feature.
  assign to_fire_s = 1'b0 & (TIMEOUT_BITS == 0);
`endif

  // Byte pairing, word/frame numbering and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte_r     <= 8'd0;
      byte_valid_r  <= 1'b0;
      word_r        <= 16'd0;
      word_valid_r  <= 1'b0;
      word_idx_r    <= 4'd0;
      frame_done_r  <= 1'b0;
      framing_err_r <= 1'b0;
      timeout_r     <= 1'b0;
      hi_r          <= 8'd0;
      pend_r        <= 1'b0;
      cnt_r         <= 4'd0;
    end else begin
      byte_valid_r  <= core_ok_s;
      framing_err_r <= core_bad_s;
      timeout_r     <= to_fire_s;
      word_valid_r  <= 1'b0;
      frame_done_r  <= 1'b0;
      if (core_ok_s) begin
        rx_byte_r <= core_data_s;
        if (pend_r) begin
          word_r       <= {hi_r, core_data_s};
          word_valid_r <= 1'b1;
          word_idx_r   <= cnt_r;
          frame_done_r <= (cnt_r == LAST_IDX);
          cnt_r        <= (cnt_r == LAST_IDX) ? 4'd0 : (cnt_r + 4'd1);
          pend_r       <= 1'b0;
        end else begin
          hi_r   <= core_data_s;
          pend_r <= 1'b1;
        end
      end else if (core_bad_s) begin
        // Resynchronise pairing: the next good byte is a high byte.
        pend_r <= 1'b0;
      end else if (to_fire_s) begin
        pend_r <= 1'b0;
        cnt_r  <= 4'd0;
      end
    end
  end

  assign rx_byte     = rx_byte_r;
  assign byte_valid  = byte_valid_r;
  assign word        = word_r;
  assign word_valid  = word_valid_r;
  assign word_idx    = word_idx_r;
  assign frame_done  = frame_done_r;
  assign framing_err = framing_err_r;
  assign timeout     = timeout_r;
  assign rx_busy     = core_busy_s;

endmodule

// File: tb/tb_conv_word_rx.sv
// Directed bench for conv_word_rx. The clock is scaled so that baud_set=4
// gives an exact 16x divisor of 2 (32 clk per bit).
module tb_conv_word_rx;

  localparam int BIT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [2:0]  baud_set = 3'd4;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic [15:0] word;
  logic        word_valid;
  logic [3:0]  word_idx;
  logic        frame_done;
  logic        framing_err;
  logic        timeout;
  logic        rx_busy;

  conv_word_rx #(
    .CLK_FREQ (3_686_400)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .baud_set    (baud_set),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .word        (word),
    .word_valid  (word_valid),
    .word_idx    (word_idx),
    .frame_done  (frame_done),
    .framing_err (framing_err),
    .timeout     (timeout),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int bv_cnt = 0;
  int fe_cnt = 0;
  int fd_cnt = 0;
  int to_cnt = 0;
  int proto_err = 0;
  logic [4:0]  prev_p = 5'd0;
  logic [15:0] w_q[$];
  logic [3:0]  i_q[$];
  logic        f_q[$];

  // Event recorder: logs every word and pulse, flags multi-cycle pulses and
  // illegal pulse combinations.
  always @(negedge clk) begin
    if (rst) begin
      prev_p <= 5'd0;
    end else begin
      prev_p <= {byte_valid, word_valid, frame_done, framing_err, timeout};
      if ((|({byte_valid, word_valid, frame_done, framing_err, timeout} & prev_p)) ||
          (byte_valid && framing_err) || (byte_valid && timeout) ||
          (frame_done && !word_valid) || (word_valid && !byte_valid)) begin
        proto_err <= proto_err + 1;
      end
      if (byte_valid)  bv_cnt <= bv_cnt + 1;
      if (framing_err) fe_cnt <= fe_cnt + 1;
      if (frame_done)  fd_cnt <= fd_cnt + 1;
      if (timeout)     to_cnt <= to_cnt + 1;
      if (word_valid) begin
        w_q.push_back(word);
        i_q.push_back(word_idx);
        f_q.push_back(frame_done);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8N1 character; optionally checks the 3-clk edge-to-busy latency.
  task automatic send_byte(input logic [7:0] d, input logic stop_v, input bit chk_lat);
    @(negedge clk);
    rx = 1'b0;
    if (chk_lat) begin
      repeat (2) @(negedge clk);
      chk("edge_lat_2clk_idle", rx_busy, 0);
      @(negedge clk);
      chk("edge_lat_3clk_busy", rx_busy, 1);
      repeat (BIT - 3) @(negedge clk);
    end else begin
      repeat (BIT) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_v;
    repeat (BIT) @(negedge clk);
    if (!stop_v) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end
  endtask

  int  b;
  int  bv0;
  int  fe0;
  bit  seen;
  bit  dropped;
  logic [7:0] pd;

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_word", word, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_pulses", {byte_valid, word_valid, frame_done, framing_err, timeout}, 0);
    chk("rst_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single pair
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h23, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("pair_wv_cnt", w_q.size(), 1);
    chk("pair_word", w_q[0], 16'h0123);
    chk("pair_idx", i_q[0], 0);
    chk("pair_fd", fd_cnt, 0);
    chk("pair_bv_cnt", bv_cnt, 2);
    chk("pair_rx_byte", rx_byte, 8'h23);
    chk("pair_word_hold", word, 16'h0123);

    // Full frame from a clean count
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    b = w_q.size();
    for (int k = 0; k < 16; k++) begin
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'h30 + 8'(k), 1'b1, 1'b0);
    end
    repeat (8) @(negedge clk);
    chk("frame_wv_cnt", w_q.size() - b, 16);
    for (int k = 0; k < 16; k++) begin
      chk("frame_word", w_q[b + k], 16'h0030 + 16'(k));
      chk("frame_idx", i_q[b + k], k);
      chk("frame_fd", f_q[b + k], (k == 15) ? 1 : 0);
    end
    chk("frame_fd_cnt", fd_cnt, 1);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h40, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("wrap_word", w_q[b + 16], 16'h0040);
    chk("wrap_idx", i_q[b + 16], 0);
    chk("wrap_fd_cnt", fd_cnt, 1);

    // Framing error drops the pending high byte
    b = w_q.size();
    fe0 = fe_cnt;
    bv0 = bv_cnt;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("fe_cnt", fe_cnt - fe0, 1);
    chk("fe_bv_cnt", bv_cnt - bv0, 3);
    chk("fe_wv_cnt", w_q.size() - b, 1);
    chk("fe_word", word, 16'h1234);
    chk("fe_idx", word_idx, 1);

    // False start: quarter-bit glitch
    b = w_q.size();
    fe0 = fe_cnt;
    bv0 = bv_cnt;
    seen = 1'b0;
    dropped = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    for (int n = 0; n < BIT / 4; n++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    rx = 1'b1;
    for (int n = 0; n < BIT; n++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
      if (seen && !rx_busy) dropped = 1'b1;
    end
    chk("fs_busy_seen", seen, 1);
    chk("fs_busy_drop", dropped, 1);
    chk("fs_no_byte", bv_cnt - bv0, 0);
    chk("fs_no_fe", fe_cnt - fe0, 0);
    chk("fs_no_word", w_q.size() - b, 0);
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("fs_recover_word", word, 16'h5AC3);
    chk("fs_recover_idx", word_idx, 2);

    // Stale high byte followed by a long idle line
    b = w_q.size();
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (21 * BIT) @(negedge clk);
`ifdef CONV_WORD_RX_TIMEOUT_EN
    chk("to_pulse", to_cnt, 1);
    send_byte(8'h66, 1'b1, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("to_word", word, 16'h6677);
    chk("to_idx", word_idx, 0);
    chk("to_wv_cnt", w_q.size() - b, 1);
    chk("to_single", to_cnt, 1);
    send_byte(8'h11, 1'b1, 1'b0);
`else
    chk("to_absent", to_cnt, 0);
    send_byte(8'h66, 1'b1, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("nto_word", word, 16'h5566);
    chk("nto_idx", word_idx, 3);
    chk("nto_wv_cnt", w_q.size() - b, 1);
`endif

    // Reset during bit 4 of a low byte
    b = w_q.size();
    pd = 8'hA5;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = pd[i];
      repeat (BIT) @(negedge clk);
    end
    rx = pd[4];
    repeat (BIT / 2) @(negedge clk);
    chk("mid_busy", rx_busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_rx_byte", rx_byte, 0);
    chk("mrst_word", word, 0);
    chk("mrst_idx", word_idx, 0);
    chk("mrst_pulses", {byte_valid, word_valid, frame_done, framing_err, timeout}, 0);
    chk("mrst_busy", rx_busy, 0);
    rx = 1'b1;
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk("mrst_no_word", w_q.size() - b, 0);
    chk("mrst_idle", rx_busy, 0);
    send_byte(8'hBE, 1'b1, 1'b0);
    send_byte(8'hEF, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("mrst_word_after", word, 16'hBEEF);
    chk("mrst_idx_after", word_idx, 0);
    chk("mrst_wv_cnt", w_q.size() - b, 1);

    chk("pulse_protocol", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
